// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: buffered 8N1 UART slave on the core's CSR bus.
//
// A TX FIFO and an RX FIFO decouple firmware from the serial line timing.
// The DATA register at BASE_ADDR pushes TX bytes and pops RX bytes.
// The STATUS register at BASE_ADDR+1 holds the FIFO counts and the sticky
// error flags, which are cleared by writing 1.
//
// Optional feature macro: CSR_UART_FIFO_LOOPBACK_EN
//   When defined, STATUS[19] is a loopback bit. When it is set, the
//   receiver listens to the internal transmitter and pin tx is held idle.
//
// Ports:
//   clk     clock
//   rst     synchronous reset, active-high
//   read    CSR read strobe; pops the RX FIFO when DATA is addressed
//   modify  CSR write kind: 001 replace, 010 set bits, 100 clear bits
//   wdata   CSR write data
//   addr    CSR address
//   rdata   read data, combinational from addr; 0 when not decoded
//   valid   addr hits DATA or STATUS
//   rx      asynchronous serial input
//   tx      serial output, idle high

module csr_uart_fifo_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [7:0]          wdata,
  input  logic                pop,
  output logic [7:0]          head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on an empty FIFO is ignored; a push on a full FIFO only
  // lands when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hBC0,
  parameter int          CLOCK_RATE = 12_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx
);
  localparam int DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF  = CNT_W'(DIV / 2);
  localparam logic [11:0]      STAT_ADDR = BASE_ADDR + 12'd1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic hit_data, hit_stat;
  logic wr_replace, wr_set, wr_clear;

  logic [7:0]            tx_head, rx_head;
  logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push_req, tx_pop, tx_drop;
  logic                  rx_push_req, rx_pop, rx_drop, rx_ferr;

  logic                  rx_ovr, tx_ovf, frame_err, lb;
  logic [2:0]            flag_clr;

  state_t                tx_st;
  logic [CNT_W-1:0]      tx_tick;
  logic [2:0]            tx_bitn;
  logic [7:0]            tx_sh;
  logic                  tx_q;
  logic                  tx_bit_end;

  state_t                rx_st;
  logic [CNT_W-1:0]      rx_tick;
  logic [2:0]            rx_bitn;
  logic [7:0]            rx_sh;
  logic                  rx_in, rx_s1, rx_s2, rx_prev;
  logic                  rx_bit_end;

  logic [31:0]           data_rd, status_rd;
  logic                  unused_ok;

  assign hit_data   = (addr == BASE_ADDR);
  assign hit_stat   = (addr == STAT_ADDR);
  assign valid      = hit_data || hit_stat;
  assign wr_replace = (modify == 3'b001);
  assign wr_set     = (modify == 3'b010);
  assign wr_clear   = (modify == 3'b100);
  assign unused_ok  = ^wdata[31:8];

  assign tx_push_req = hit_data && wr_replace;
  assign rx_pop      = hit_data && read;
  assign tx_drop     = tx_push_req && tx_full && !tx_pop;

  csr_uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_req),
    .wdata (wdata[7:0]),
    .pop   (tx_pop),
    .head  (tx_head),
    .count (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  csr_uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_req),
    .wdata (rx_sh),
    .pop   (rx_pop),
    .head  (rx_head),
    .count (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // CSR read mux
  always_comb begin
    data_rd      = '0;
    data_rd[7:0] = rx_empty ? 8'h00 : rx_head;
    data_rd[8]   = rx_empty;
    data_rd[9]   = tx_full;

    status_rd                   = '0;
    status_rd[DEPTH_LOG2:0]     = tx_cnt;
    status_rd[DEPTH_LOG2+8:8]   = rx_cnt;
    status_rd[16]               = rx_ovr;
    status_rd[17]               = tx_ovf;
    status_rd[18]               = frame_err;
    status_rd[19]               = lb;

    rdata = '0;
    if (hit_data)      rdata = data_rd;
    else if (hit_stat) rdata = status_rd;
  end

  // Sticky flags: a new event in the same cycle wins over a clear.
  assign flag_clr = (hit_stat && (wr_replace || wr_clear)) ? wdata[18:16] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (flag_clr[0]) rx_ovr    <= 1'b0;
      if (flag_clr[1]) tx_ovf    <= 1'b0;
      if (flag_clr[2]) frame_err <= 1'b0;
      if (rx_drop)     rx_ovr    <= 1'b1;
      if (tx_drop)     tx_ovf    <= 1'b1;
      if (rx_ferr)     frame_err <= 1'b1;
    end
  end

`ifdef CSR_UART_FIFO_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lb <= 1'b0;
    end else if (hit_stat) begin
      if (wr_replace)                lb <= wdata[19];
      else if (wr_set && wdata[19])  lb <= 1'b1;
      else if (wr_clear && wdata[19]) lb <= 1'b0;
    end
  end
  assign rx_in = lb ? tx_q : rx;
  assign tx    = tx_q | lb;
`else
  assign lb    = 1'b0;
  assign rx_in = rx;
  assign tx    = tx_q;
`endif

  // Transmitter: the next frame is fetched at the end of the stop bit so
  // back-to-back bytes leave without an idle gap.
  assign tx_bit_end = (tx_tick == DIV_LAST);
  assign tx_pop     = !tx_empty &&
                      ((tx_st == S_IDLE) || ((tx_st == S_STOP) && tx_bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= S_IDLE;
      tx_tick <= '0;
      tx_bitn <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: begin
          tx_tick <= '0;
          if (tx_pop) begin
            tx_st <= S_START;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_tick <= '0;
            tx_bitn <= '0;
            tx_q    <= tx_sh[0];
            tx_st   <= S_DATA;
          end else begin
            tx_tick <= tx_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_tick <= '0;
            if (tx_bitn == 3'd7) begin
              tx_q  <= 1'b1;
              tx_st <= S_STOP;
            end else begin
              tx_q    <= tx_sh[tx_bitn + 3'd1];
              tx_bitn <= tx_bitn + 3'd1;
            end
          end else begin
            tx_tick <= tx_tick + 1'b1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_tick <= '0;
            if (tx_pop) begin
              tx_q  <= 1'b0;
              tx_st <= S_START;
            end else begin
              tx_st <= S_IDLE;
            end
          end else begin
            tx_tick <= tx_tick + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) tx_sh <= tx_head;
  end

  // Receiver: two-flop synchroniser, then falling-edge start detection.
  // Requiring an edge also makes the receiver wait for the line to return
  // high after a framing error before it re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_bit_end  = (rx_tick == DIV_LAST);
  assign rx_push_req = (rx_st == S_STOP) && rx_bit_end && rx_s2;
  assign rx_drop     = rx_push_req && rx_full && !rx_pop;
  assign rx_ferr     = (rx_st == S_STOP) && rx_bit_end && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= S_IDLE;
      rx_tick <= '0;
      rx_bitn <= '0;
    end else begin
      case (rx_st)
        S_IDLE: begin
          rx_tick <= '0;
          if (rx_prev && !rx_s2) rx_st <= S_START;
        end
        S_START: begin
          if (rx_tick == DIV_HALF) begin
            rx_tick <= '0;
            rx_bitn <= '0;
            rx_st   <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_tick <= '0;
            rx_bitn <= rx_bitn + 3'd1;
            if (rx_bitn == 3'd7) rx_st <= S_STOP;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        default: begin
          if (rx_bit_end) begin
            rx_tick <= '0;
            rx_st   <= S_IDLE;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((rx_st == S_DATA) && rx_bit_end) rx_sh <= {rx_s2, rx_sh[7:1]};
  end
endmodule

// File: tb/tb_csr_uart_fifo.sv
module tb_csr_uart_fifo;
  localparam int DIV = 104;
  localparam logic [11:0] A_DATA = 12'hBC0;
  localparam logic [11:0] A_STAT = 12'hBC1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'b000;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        rx = 1'b1;
  logic        tx;

  int errors = 0;
  int checks = 0;
  int rx_model_cnt = 0;
  int tx_falls = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  csr_uart_fifo dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .rx     (rx),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  always @(negedge tx) tx_falls++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [2:0] m, input logic [31:0] d);
    @(negedge clk);
    addr = a; modify = m; wdata = d;
    @(negedge clk);
    modify = 3'b000;
  endtask

  task automatic csr_peek(input logic [11:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    addr = a; read = 1'b0;
    #1;
    d = rdata; v = valid;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; read = 1'b1;
    #1;
    d = rdata;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] b, input bit expect_out);
    if (expect_out) tx_exp.push_back(b);
    csr_wr(A_DATA, 3'b001, {24'h0, b});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit && rx_model_cnt < 16) begin
      rx_exp.push_back(b);
      rx_model_cnt++;
    end
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic rx_pop_check();
    logic [31:0] d;
    logic [7:0]  e;
    csr_rd(A_DATA, d);
    if (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      rx_model_cnt--;
      chk("rx_data", d, {24'h0, e});
    end else begin
      chk("rx_empty_read", d, 32'h100);
    end
  endtask

  task automatic wait_tx_drain(input int budget);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_drain", tx_exp.size(), 0);
    repeat (DIV) @(negedge clk);
  endtask

  // Line monitor: decodes every frame at mid-bit and scores it.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge tx);
      if (tx_exp.size() == 0) begin
        chk("tx_spurious_frame", 1, 0);
      end else begin
        repeat (DIV / 2) @(negedge clk);
        chk("tx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        e = tx_exp.pop_front();
        chk("tx_byte", b, e);
        chk("tx_stop_bit", tx, 1);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          falls0;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    csr_peek(A_STAT, d, v);
    chk("rst_stat_valid", v, 1);
    chk("rst_stat", d, 32'h0);
    csr_peek(A_DATA, d, v);
    chk("rst_data_valid", v, 1);
    chk("rst_data", d, 32'h100);
    chk("rst_tx", tx, 1);
    csr_peek(12'hBC2, d, v);
    chk("undec_valid", v, 0);
    chk("undec_rdata", d, 32'h0);

    // Single byte transmit
    tx_send(8'h55, 1'b1);
    @(negedge clk);
    chk("tx_low_2cyc", tx, 0);
    repeat (1040) @(negedge clk);
    csr_peek(A_STAT, d, v);
    chk("tx_count_after", d, 32'h0);
    wait_tx_drain(2000);

    // TX overflow while the first frame is on the line
    tx_send(8'hA0, 1'b1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 17; i++) tx_send(8'h10 + 8'(i), i < 16);
    csr_peek(A_STAT, d, v);
    chk("tx_full_stat", d, 32'h0002_0010);
    csr_peek(A_DATA, d, v);
    chk("tx_full_data", d, 32'h300);
    csr_wr(A_STAT, 3'b001, 32'h0002_0000);
    csr_peek(A_STAT, d, v);
    chk("tx_ovf_clear", d, 32'h10);
    csr_wr(A_STAT, 3'b010, 32'h0007_0000);
    csr_peek(A_STAT, d, v);
    chk("sticky_no_set", d, 32'h10);
    wait_tx_drain(20000);

    // Single receive
    send_frame(8'hA3, 1'b1);
    csr_peek(A_STAT, d, v);
    chk("rx_count_1", d, 32'h100);
    rx_pop_check();
    rx_pop_check();

    // RX overflow, framing error, then re-arm
    for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b1);
    csr_peek(A_STAT, d, v);
    chk("rx_ovr_stat", d, 32'h0001_1000);
    send_frame(8'hEE, 1'b0);
    csr_peek(A_STAT, d, v);
    chk("frame_err_stat", d, 32'h0005_1000);
    for (int i = 0; i < 16; i++) rx_pop_check();
    rx_pop_check();
    csr_wr(A_STAT, 3'b100, 32'h0007_0000);
    csr_peek(A_STAT, d, v);
    chk("flags_cleared", d, 32'h0);
    send_frame(8'h5A, 1'b1);
    rx_pop_check();

`ifdef CSR_UART_FIFO_LOOPBACK_EN
    csr_wr(A_STAT, 3'b010, 32'h0008_0000);
    csr_peek(A_STAT, d, v);
    chk("lb_set", d, 32'h0008_0000);
    falls0 = tx_falls;
    rx_exp.push_back(8'hC4);
    rx_model_cnt++;
    tx_send(8'hC4, 1'b0);
    repeat (1200) @(negedge clk);
    rx_pop_check();
    chk("lb_tx_quiet", tx_falls - falls0, 0);
    csr_wr(A_STAT, 3'b100, 32'h0008_0000);
    csr_peek(A_STAT, d, v);
    chk("lb_clear", d, 32'h0);
`else
    falls0 = tx_falls;
    csr_wr(A_STAT, 3'b001, 32'h0008_0000);
    csr_peek(A_STAT, d, v);
    chk("lb_absent", d, 32'h0);
    chk("lb_absent_tx", tx_falls - falls0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_uart_fifo.md
Name: csr_uart_fifo

Overview:
Buffered 8N1 UART peripheral on the core's CSR bus. It sits beside the pipeline as a CSR-bus slave, and its rdata/valid are ORed into the shared csr_rdata/csr_valid.
Parametrised TX and RX FIFOs decouple the core from line timing, so boot loader and firmware can stream bytes without polling every bit time.
Status and error state are exposed through a second CSR.

Parameters:
BASE_ADDR, 12'hBC0, CSR address of DATA register; STATUS register is at BASE_ADDR+1
CLOCK_RATE, 12_000_000, clk frequency in Hz
BAUD_RATE, 115200, line rate; bit period DIV = CLOCK_RATE/BAUD_RATE, integer-truncated (104 at defaults)
DEPTH_LOG2, 4, log2 of each FIFO's depth (16 entries at default); legal range 1..7

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
read  in  1  CSR read strobe
modify  in  3  CSR write kind: 001 = replace, 010 = set bits, 100 = clear bits, 000 = none
wdata  in  32  CSR write data
addr  in  12  CSR address
rdata  out  32  read data; 0 when addr is not decoded
valid  out  1  addr decodes to DATA or STATUS
rx  in  1  serial input, asynchronous
tx  out  1  serial output

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: tx=1, both FIFOs empty, all sticky flags 0, TX and RX FSMs in IDLE, RX synchroniser preset to 1.
- valid and rdata are combinational from addr in the same cycle. Pops and pushes take effect at the next clk edge.
- DATA read value:
  - [7:0] = RX FIFO head.
  - [8] = rx_empty; when 1, [7:0] reads 0.
  - [9] = tx_full.
  - Other bits 0.
- DATA side effects:
  - read=1 with RX FIFO non-empty pops one entry.
  - modify=001 pushes wdata[7:0] to the TX FIFO. If the TX FIFO is full, the byte is dropped and tx_ovf is set.
  - modify=010 and modify=100 are ignored on DATA.
  - Read and push in the same cycle both take effect.
- STATUS read value:
  - [DEPTH_LOG2:0] = tx_count.
  - [15:8] = rx_count, zero-extended.
  - [16] = rx_ovr; [17] = tx_ovf; [18] = frame_err.
  - [19] = loopback (0 when the optional feature is absent).
- STATUS writes:
  - Sticky flags [18:16] are cleared by writing 1: a 1 under modify=001 or modify=100 clears the bit.
  - modify=010 never sets the sticky flags.
  - Counts are read-only.
- FIFO: circular buffer with DEPTH_LOG2-bit pointers wrapping mod depth and a (DEPTH_LOG2+1)-bit count; full when count = depth.
  - Simultaneous push and pop on a full FIFO: both occur, count is unchanged.
  - Simultaneous push and pop on an empty FIFO: the push occurs, the pop is ignored.
- TX FSM, states IDLE, START, DATA, STOP; a bit counter counts DIV clocks per bit.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START (tx=0).
  - DATA: shifts 8 bits, LSB first.
  - STOP: drives tx=1 for one bit period, then returns to IDLE.
  - Back-to-back frames have no extra idle gap.
- RX input path: rx passes through a 2-flop synchroniser.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE → START on a synchronised falling edge.
  - START: sample at DIV/2. If the line is high, the start was a glitch; return to IDLE.
  - DATA: 8 samples, spaced DIV apart.
  - STOP: sample. If 1 and the FIFO is not full, push the byte. If 1 and the FIFO is full, drop the byte and set rx_ovr. If 0, drop the byte, set frame_err, and wait in IDLE for the line to go high before re-arming.
- Reset mid-frame: both FSMs abort immediately, tx=1, no partial byte is pushed.

Optional Feature:
CSR_UART_FIFO_LOOPBACK_EN
- Defined:
  - STATUS[19] is a read/write loopback bit, written by modify 001/010/100 with normal semantics.
  - When loopback=1, the RX synchroniser input is the internal tx signal instead of pin rx, and pin tx is held at 1.
- Undefined: STATUS[19] reads 0, writes are ignored, and rx is always the pin.

Test Plan:
- Reset, then read STATUS at 12'hBC1 → valid=1, rdata=32'h0; read DATA → rdata=32'h100; tx=1; addr 12'hBC2 → valid=0, rdata=0.
- Write 8'h55 to DATA → tx goes low within 2 cycles; line pattern 0,1,0,1,0,1,0,1,0,1 at 104 clk per bit; tx_count returns to 0 after 1040 cycles.
- Write 17 bytes back-to-back with tx stalled in the first frame → tx_count=16, 17th byte dropped, STATUS[17]=1; writing 32'h20000 with modify=001 clears it.
- Drive frame 8'hA3 on rx → rx_count=1; DATA read returns 32'h0A3 and pops; next read returns 32'h100.
- Drive 17 frames without reading → rx_count=16, STATUS[16]=1, first 16 bytes intact in order; drive a frame with stop bit 0 → STATUS[18]=1, rx_count unchanged.
- With CSR_UART_FIFO_LOOPBACK_EN: set STATUS[19], write 8'hC4 → after ~1040 cycles DATA reads 32'h0C4 and pin tx stays 1 throughout.
